if_fetch_unit: RTL

//  Instruction fetch front end that feeds the IF/ID pipeline register. It owns the fetch PC and

---
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
// Signal suffixes are relative to the fetch unit.
interface if_fetch_unit_if;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_rdata_i;

  modport master (
    output imem_req_valid_o,
    output imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_resp_valid_i,
    input  imem_resp_rdata_i
  );

  modport slave (
    input  imem_req_valid_o,
    input  imem_req_addr_o,
    output imem_req_ready_i,
    output imem_resp_valid_i,
    output imem_resp_rdata_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: credit-limited in-order imem requests feeding a prefetch FIFO.
// Optional feature: define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [31:0]     redirect_pc_i,
  if_fetch_unit_if.master imem,
  output logic            valid_o,
  output logic [31:0]     pc_o,
  output logic [31:0]     instr_o,
  output logic            misalign_o
);
  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW      = AW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_MASK = ~32'h0000_0003;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];

  logic          fetch_blocked;
  logic [CW:0]   inflight;
  logic          req_valid;
  logic          accept;
  logic          resp_in;
  logic          push;
  logic          pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect_i) begin
      misalign_d = |redirect_pc_i[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_blocked = misalign_q;
`else
  assign fetch_blocked = 1'b0;
`endif

  assign misalign_o = fetch_blocked;

  // Credit covers both in-flight requests and buffered words, so a response always has a slot.
  assign inflight  = {1'b0, outst_q} + {1'b0, cnt_q};
  assign req_valid = !rst && !redirect_i && !fetch_blocked && (inflight < (CW+1)'(FIFO_DEPTH));
  assign accept    = req_valid && imem.imem_req_ready_i;
  assign resp_in   = imem.imem_resp_valid_i;
  assign push      = resp_in && (drop_q == '0) && !redirect_i;

  assign imem.imem_req_valid_o = req_valid;
  assign imem.imem_req_addr_o  = fetch_pc_q;

  assign valid_o = (cnt_q != '0) && !fetch_blocked;
  assign pc_o    = valid_o ? fifo_pc_q[rd_ptr_q] : 32'h0;
  assign instr_o = valid_o ? fifo_instr_q[rd_ptr_q] : NOP;
  assign pop     = valid_o && !stall_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(accept) - CW'(resp_in);
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (resp_in && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wr_ptr_d  = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    // Every request still in flight after this cycle belongs to the old path.
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & PC_MASK;
      resp_pc_d  = redirect_pc_i & PC_MASK;
      drop_d     = outst_d;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem.imem_resp_rdata_i;
    end
  end

  push_into_full_fifo: assert property (@(posedge clk) disable iff (rst)
    !(push && (cnt_q == CW'(FIFO_DEPTH))));

endmodule
